// File: rtl/layer_5_maxpool.sv
`default_nettype none
// ============================================================================
// Module      : layer_5_maxpool
// Description : 2x2 stride-2 max-pool over a raster-order FP32 pixel stream
//               (YOLOv3-Tiny layer 5). Horizontal pairs are reduced on the
//               fly; even-row pair maxima wait in a half-width line buffer
//               for the matching odd-row pair maxima.
//               Optional build macro LAYER_5_MAXPOOL_RELU_EN clamps negative
//               inputs to +0 before pooling (ReLU + pool).
// Revision    : 1.0 - initial release
// ============================================================================
module layer_5_maxpool #(
    parameter int DATA_WIDTH = 32,
    parameter int IMG_SIZE   = 104
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out
);

    localparam int c_HALF = IMG_SIZE / 2;
    localparam int c_CW   = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(IMG_SIZE - 1);

    // Monotonic ordering key for FP32 bit patterns (larger key = larger value)
    function automatic logic [DATA_WIDTH-1:0] key(input logic [DATA_WIDTH-1:0] x);
        return x[DATA_WIDTH-1] ? ~x : (x ^ {1'b1, {(DATA_WIDTH-1){1'b0}}});
    endfunction

    // True when b must replace a; +0 and -0 count as a tie so the first wins
    function automatic logic later_wins(input logic [DATA_WIDTH-1:0] a,
                                        input logic [DATA_WIDTH-1:0] b);
        logic both_zero;
        both_zero = (a[DATA_WIDTH-2:0] == '0) && (b[DATA_WIDTH-2:0] == '0);
        return (key(b) > key(a)) && !both_zero;
    endfunction

    logic [c_CW-1:0]       col_cnt_q, col_cnt_d;
    logic [c_CW-1:0]       row_cnt_q, row_cnt_d;
    logic [DATA_WIDTH-1:0] h_reg_q, h_reg_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  valid_out_q, valid_out_d;
    logic [DATA_WIDTH-1:0] line_buf_q [c_HALF];
    logic [DATA_WIDTH-1:0] line_buf_d [c_HALF];

    logic [DATA_WIDTH-1:0] w_pix;
    logic [DATA_WIDTH-1:0] w_hmax;
    logic [DATA_WIDTH-1:0] w_top;
    logic [DATA_WIDTH-1:0] w_vmax;
    logic [c_CW-1:0]       w_col_half;
    logic                  w_col_odd;
    logic                  w_row_odd;

    assign w_col_half = col_cnt_q >> 1;
    assign w_col_odd  = col_cnt_q[0];
    assign w_row_odd  = row_cnt_q[0];

    // Input conditioning: optional ReLU clamp of negative pixels to +0
`ifdef LAYER_5_MAXPOOL_RELU_EN
    assign w_pix = data_in[DATA_WIDTH-1] ? '0 : data_in;
`else
    assign w_pix = data_in;
`endif

    // Horizontal max of the held even-column pixel and the current odd-column pixel
    assign w_hmax = later_wins(h_reg_q, w_pix) ? w_pix : h_reg_q;

    // Asynchronous read of the even-row pair maximum for this column pair
    always_comb begin
        w_top = '0;
        for (int i = 0; i < c_HALF; i++) begin
            if (w_col_half == c_CW'(i)) begin
                w_top = line_buf_q[i];
            end
        end
    end

    // Vertical max, top row wins ties
    assign w_vmax = later_wins(w_top, w_hmax) ? w_hmax : w_top;

    // Next-state: raster counters, horizontal hold, output register
    always_comb begin
        col_cnt_d   = col_cnt_q;
        row_cnt_d   = row_cnt_q;
        h_reg_d     = h_reg_q;
        data_out_d  = data_out_q;
        valid_out_d = 1'b0;
        if (valid_in) begin
            if (col_cnt_q == c_LAST) begin
                col_cnt_d = '0;
                row_cnt_d = (row_cnt_q == c_LAST) ? '0 : row_cnt_q + 1'b1;
            end else begin
                col_cnt_d = col_cnt_q + 1'b1;
            end
            if (!w_col_odd) begin
                h_reg_d = w_pix;
            end else if (w_row_odd) begin
                data_out_d  = w_vmax;
                valid_out_d = 1'b1;
            end
        end
    end

    // Next-state: line buffer write of even-row pair maxima
    always_comb begin
        line_buf_d = line_buf_q;
        for (int i = 0; i < c_HALF; i++) begin
            if (valid_in && w_col_odd && !w_row_odd && (w_col_half == c_CW'(i))) begin
                line_buf_d[i] = w_hmax;
            end
        end
    end

    // Control and output registers with asynchronous active-low reset
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            col_cnt_q   <= '0;
            row_cnt_q   <= '0;
            h_reg_q     <= '0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
        end else begin
            col_cnt_q   <= col_cnt_d;
            row_cnt_q   <= row_cnt_d;
            h_reg_q     <= h_reg_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
        end
    end

    // Line buffer storage; contents are don't-care after reset
    always_ff @(posedge Clk) begin
        line_buf_q <= line_buf_d;
    end

    assign data_out  = data_out_q;
    assign valid_out = valid_out_q;

endmodule
`default_nettype wire

// File: tb/tb_layer_5_maxpool.sv
`default_nettype none
// ============================================================================
// Module      : tb_layer_5_maxpool
// Description : Self-checking bench for layer_5_maxpool at IMG_SIZE=4 with a
//               block-level max-pool reference model. Honours
//               LAYER_5_MAXPOOL_RELU_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_layer_5_maxpool;

    localparam int c_N = 4;
    localparam int c_PIX = c_N * c_N;

    logic        Clk;
    logic        Rst;
    logic [31:0] data_in;
    logic        valid_in;
    logic [31:0] data_out;
    logic        valid_out;

    int errors;
    int checks;

    // Reference model state: pixels of the current frame and last pooled value
    logic [31:0] m_frame [c_PIX];
    int          m_idx;
    logic [31:0] m_last;

    logic [31:0] ramp [c_PIX] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                                  32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
                                  32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
                                  32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000};
    logic [31:0] ramp_pool [4] = '{32'h40C00000, 32'h41000000, 32'h41600000, 32'h41800000};
    logic [31:0] pool_vals [4] = '{32'h3F800000, 32'hBF800000, 32'h40400000, 32'hC0400000};

    layer_5_maxpool #(
        .DATA_WIDTH (32),
        .IMG_SIZE   (c_N)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .data_out  (data_out),
        .valid_out (valid_out)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Real-number ordering of FP32 patterns; signed zeros compare equal
    function automatic logic fp_gt(input logic [31:0] a, input logic [31:0] b);
        if (a[30:0] == 0 && b[30:0] == 0) return 1'b0;
        if (a[31] != b[31]) return b[31];
        if (!a[31]) return a[30:0] > b[30:0];
        return a[30:0] < b[30:0];
    endfunction

    function automatic logic [31:0] relu(input logic [31:0] x);
`ifdef LAYER_5_MAXPOOL_RELU_EN
        return x[31] ? 32'h0 : x;
`else
        return x;
`endif
    endfunction

    function automatic logic [31:0] gen_px();
        case ($urandom_range(0, 4))
            0: return ($urandom_range(0, 1) == 1) ? 32'h80000000 : 32'h0;
            1: return pool_vals[$urandom_range(0, 3)];
            default: return {1'($urandom_range(0, 1)), 8'($urandom_range(120, 134)), 23'($urandom)};
        endcase
    endfunction

    task automatic model_reset();
        m_idx  = 0;
        m_last = 32'h0;
    endtask

    // Record a pixel; when it closes a 2x2 block, the block maximum (first seen wins ties) is due
    task automatic model_push(input logic [31:0] px, output logic ev, output logic [31:0] ed);
        int r, c, base;
        logic [31:0] best;
        m_frame[m_idx] = relu(px);
        r = m_idx / c_N;
        c = m_idx % c_N;
        ev = 1'b0;
        if ((r % 2 == 1) && (c % 2 == 1)) begin
            base = (r - 1) * c_N + (c - 1);
            best = m_frame[base];
            if (fp_gt(m_frame[base + 1], best))       best = m_frame[base + 1];
            if (fp_gt(m_frame[base + c_N], best))     best = m_frame[base + c_N];
            if (fp_gt(m_frame[base + c_N + 1], best)) best = m_frame[base + c_N + 1];
            m_last = best;
            ev = 1'b1;
        end
        ed = m_last;
        m_idx = (m_idx + 1) % c_PIX;
    endtask

    // Drive one cycle of input and settle just after the active edge
    task automatic step(input logic v, input logic [31:0] d);
        @(negedge Clk);
        valid_in = v;
        data_in  = d;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Rst = 1'b0;
        valid_in = 1'b0;
        data_in = 32'h0;
        repeat (2) @(posedge Clk);
        #1;
        checks++;
        if (valid_out !== 1'b0 || data_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_hold: valid_out=%b data_out=%h, want 0/00000000", valid_out, data_out);
        end
        @(negedge Clk);
        Rst = 1'b1;
        step(1'b0, 32'h12345678);
        checks++;
        if (valid_out !== 1'b0 || data_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_release: valid_out=%b data_out=%h, want 0/00000000", valid_out, data_out);
        end
        model_reset();
    endtask

    task automatic test_ramp();
        logic ev;
        logic [31:0] ed;
        int k;
        k = 0;
        for (int i = 0; i < c_PIX; i++) begin
            step(1'b1, ramp[i]);
            model_push(ramp[i], ev, ed);
            checks++;
            if (valid_out !== ev || data_out !== ed) begin
                errors++;
                $display("FAIL ramp px%0d: valid_out=%b data_out=%h, want %b/%h", i, valid_out, data_out, ev, ed);
            end
            if (ev) begin
                checks++;
                if (data_out !== ramp_pool[k]) begin
                    errors++;
                    $display("FAIL ramp_const out%0d: data_out=%h, want %h", k, data_out, ramp_pool[k]);
                end
                k++;
            end
        end
    endtask

    task automatic test_sign();
        logic ev;
        logic [31:0] ed;
        logic [31:0] f;
        logic [31:0] first_neg;
        logic [31:0] first_zero;
        first_neg = relu(32'hBF000000);
        first_zero = relu(32'h80000000);
        for (int fr = 0; fr < 2; fr++) begin
            for (int i = 0; i < c_PIX; i++) begin
                if (fr == 0) f = (i == 4) ? 32'hBF000000 : 32'hBF800000;
                else f = ((i % 3) == 0) ? 32'h80000000 : 32'h0;
                step(1'b1, f);
                model_push(f, ev, ed);
                checks++;
                if (valid_out !== ev || data_out !== ed) begin
                    errors++;
                    $display("FAIL sign f%0d px%0d: valid_out=%b data_out=%h, want %b/%h", fr, i, valid_out, data_out, ev, ed);
                end
                if (i == 5) begin
                    checks++;
                    if (data_out !== ((fr == 0) ? first_neg : first_zero)) begin
                        errors++;
                        $display("FAIL sign_const f%0d: data_out=%h, want %h", fr, data_out, (fr == 0) ? first_neg : first_zero);
                    end
                end
            end
        end
    endtask

    task automatic test_gaps();
        logic ev;
        logic [31:0] ed;
        for (int i = 0; i < c_PIX; i++) begin
            while ($urandom_range(0, 1) == 1) begin
                step(1'b0, $urandom);
                checks++;
                if (valid_out !== 1'b0 || data_out !== m_last) begin
                    errors++;
                    $display("FAIL gaps idle: valid_out=%b data_out=%h, want 0/%h", valid_out, data_out, m_last);
                end
            end
            step(1'b1, ramp[i]);
            model_push(ramp[i], ev, ed);
            checks++;
            if (valid_out !== ev || data_out !== ed) begin
                errors++;
                $display("FAIL gaps px%0d: valid_out=%b data_out=%h, want %b/%h", i, valid_out, data_out, ev, ed);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic ev;
        logic [31:0] ed;
        logic [31:0] f;
        for (int i = 0; i < 2 * c_PIX; i++) begin
            f = gen_px();
            step(1'b1, f);
            model_push(f, ev, ed);
            checks++;
            if (valid_out !== ev || data_out !== ed) begin
                errors++;
                $display("FAIL b2b px%0d: valid_out=%b data_out=%h, want %b/%h", i, valid_out, data_out, ev, ed);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic ev;
        logic [31:0] ed;
        for (int i = 0; i < 7; i++) begin
            step(1'b1, ramp[i]);
            model_push(ramp[i], ev, ed);
            checks++;
            if (valid_out !== ev || data_out !== ed) begin
                errors++;
                $display("FAIL midrst pre px%0d: valid_out=%b data_out=%h, want %b/%h", i, valid_out, data_out, ev, ed);
            end
        end
        @(negedge Clk);
        valid_in = 1'b0;
        Rst = 1'b0;
        #1;
        checks++;
        if (valid_out !== 1'b0 || data_out !== 32'h0) begin
            errors++;
            $display("FAIL midrst async: valid_out=%b data_out=%h, want 0/00000000", valid_out, data_out);
        end
        @(posedge Clk);
        #1;
        checks++;
        if (valid_out !== 1'b0) begin
            errors++;
            $display("FAIL midrst held: valid_out=%b, want 0", valid_out);
        end
        @(negedge Clk);
        Rst = 1'b1;
        model_reset();
        for (int i = 0; i < c_PIX; i++) begin
            step(1'b1, ramp[i]);
            model_push(ramp[i], ev, ed);
            checks++;
            if (valid_out !== ev || data_out !== ed) begin
                errors++;
                $display("FAIL midrst post px%0d: valid_out=%b data_out=%h, want %b/%h", i, valid_out, data_out, ev, ed);
            end
        end
    endtask

    task automatic test_random();
        logic ev;
        logic [31:0] ed;
        logic [31:0] f;
        for (int i = 0; i < 8 * c_PIX; i++) begin
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                step(1'b0, $urandom);
                checks++;
                if (valid_out !== 1'b0 || data_out !== m_last) begin
                    errors++;
                    $display("FAIL random idle: valid_out=%b data_out=%h, want 0/%h", valid_out, data_out, m_last);
                end
            end
            f = gen_px();
            step(1'b1, f);
            model_push(f, ev, ed);
            checks++;
            if (valid_out !== ev || data_out !== ed) begin
                errors++;
                $display("FAIL random px%0d: valid_out=%b data_out=%h, want %b/%h", i, valid_out, data_out, ev, ed);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        Rst = 1'b0;
        valid_in = 1'b0;
        data_in = 32'h0;
        model_reset();
        test_reset();
        test_ramp();
        test_sign();
        test_gaps();
        test_back_to_back();
        test_mid_reset();
        test_random();
        step(1'b0, 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
